// File: rtl/captura_jogada.sv
// Button capture: 2-flop sync, debounce, one-hot check and held request for the control unit.
// Optional macro CAPTURA_JOGADA_INVALIDA_EN enables the jogada_invalida pulse on multi-button presses.
//
// state    | meaning
// SOLTO    | idle, all buttons released, waiting for any press
// CONTANDO | counting stable cycles of the latched pattern
// PRONTA   | valid single press pending (tem_jogada), waiting for aceita
// SOLTAR   | waiting for a fully debounced release before rearming
module captura_jogada #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] botoes,
   input  logic       limpa,
   input  logic       aceita,
   output logic       tem_jogada,
   output logic [3:0] posicao,
   output logic       jogada_invalida,
   output logic [1:0] db_estado
);

   localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      SOLTO    = 2'd0,
      CONTANDO = 2'd1,
      PRONTA   = 2'd2,
      SOLTAR   = 2'd3
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [8:0]       sinc1_q, s_q;
   logic [8:0]       padrao_q, padrao_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       posicao_q, posicao_d;
   logic             invalida_q, invalida_d;
   logic             um_quente;
   logic [3:0]       indice;

   always_ff @(posedge clock) begin
      if (reset) begin
         sinc1_q    <= '0;
         s_q        <= '0;
         estado_q   <= SOLTO;
         padrao_q   <= '0;
         cnt_q      <= '0;
         posicao_q  <= '0;
         invalida_q <= 1'b0;
      end else begin
         sinc1_q    <= botoes;
         s_q        <= sinc1_q;
         estado_q   <= estado_d;
         padrao_q   <= padrao_d;
         cnt_q      <= cnt_d;
         posicao_q  <= posicao_d;
         invalida_q <= invalida_d;
      end
   end

   assign um_quente = (padrao_q != '0) && ((padrao_q & (padrao_q - 9'd1)) == '0);

   always_comb begin
      indice = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (padrao_q[i]) indice = 4'(i);
      end
   end

   always_comb begin
      estado_d   = estado_q;
      padrao_d   = padrao_q;
      cnt_d      = cnt_q;
      posicao_d  = posicao_q;
      invalida_d = 1'b0;
      // limpa wins over aceita and over a debounce completion in the same cycle
      if (limpa) begin
         estado_d = SOLTAR;
         cnt_d    = '0;
      end else begin
         case (estado_q)
            SOLTO: begin
               if (s_q != '0) begin
                  padrao_d = s_q;
                  cnt_d    = '0;
                  estado_d = CONTANDO;
               end
            end
            CONTANDO: begin
               if (s_q != padrao_q) begin
                  estado_d = SOLTO;
               end else if (cnt_q == CNT_FIM) begin
                  cnt_d = '0;
                  if (um_quente) begin
                     posicao_d = indice;
                     estado_d  = PRONTA;
                  end else begin
`ifdef CAPTURA_JOGADA_INVALIDA_EN
                     invalida_d = 1'b1;
`else
                     invalida_d = 1'b0;
`endif
                     estado_d   = SOLTAR;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PRONTA: begin
               if (aceita) begin
                  estado_d = SOLTAR;
                  cnt_d    = '0;
               end
            end
            SOLTAR: begin
               if (s_q != '0) begin
                  cnt_d = '0;
               end else if (cnt_q == CNT_FIM) begin
                  cnt_d    = '0;
                  estado_d = SOLTO;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               estado_d = SOLTO;
               cnt_d    = '0;
            end
         endcase
      end
   end

   assign tem_jogada      = (estado_q == PRONTA);
   assign db_estado       = estado_q;
   assign posicao         = posicao_q;
   assign jogada_invalida = invalida_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Bench for captura_jogada: directed scenarios plus random button traffic against a reference model.
// Expected jogada_invalida behaviour follows CAPTURA_JOGADA_INVALIDA_EN.
module tb_captura_jogada;

   localparam int D = 4;
`ifdef CAPTURA_JOGADA_INVALIDA_EN
   localparam int INV_EN = 1;
`else
   localparam int INV_EN = 0;
`endif
   localparam int E_SOLTO = 0, E_CONTANDO = 1, E_PRONTA = 2, E_SOLTAR = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] botoes = '0;
   logic       limpa = 1'b0;
   logic       aceita = 1'b0;
   logic       tem_jogada;
   logic [3:0] posicao;
   logic       jogada_invalida;
   logic [1:0] db_estado;

   int n_checks = 0;
   int n_erros  = 0;

   always #5 clock = ~clock;

   captura_jogada #(.DEBOUNCE_CYCLES(D)) dut (
      .clock           (clock),
      .reset           (reset),
      .botoes          (botoes),
      .limpa           (limpa),
      .aceita          (aceita),
      .tem_jogada      (tem_jogada),
      .posicao         (posicao),
      .jogada_invalida (jogada_invalida),
      .db_estado       (db_estado)
   );

   task automatic verifica(input string tag, input int obs, input int esp);
      n_checks++;
      if (obs !== esp) begin
         n_erros++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, esp, $time);
      end
   endtask

   // reference model: sync pipeline as two delayed copies, debounce as run lengths
   int         m_estado = E_SOLTO;
   int         m_estavel = 0;
   int         m_zeros = 0;
   logic [8:0] m_pad = '0, m_s1 = '0, m_s2 = '0;
   int         m_pos = 0;
   int         m_inv = 0;

   task automatic modelo_passo();
      logic [8:0] s;
      int inv;
      s   = m_s2;
      inv = 0;
      if (reset) begin
         m_estado = E_SOLTO; m_estavel = 0; m_zeros = 0; m_pad = '0;
         m_pos = 0; m_inv = 0; m_s1 = '0; m_s2 = '0;
      end else begin
         if (limpa) begin
            m_estado = E_SOLTAR; m_zeros = 0;
         end else if (m_estado == E_SOLTO) begin
            if (s != 0) begin
               m_pad = s; m_estavel = 0; m_estado = E_CONTANDO;
            end
         end else if (m_estado == E_CONTANDO) begin
            if (s != m_pad) m_estado = E_SOLTO;
            else begin
               m_estavel++;
               if (m_estavel == D) begin
                  if ($countones(m_pad) == 1) begin
                     m_pos = $clog2(m_pad);
                     m_estado = E_PRONTA;
                  end else begin
                     inv = INV_EN;
                     m_estado = E_SOLTAR; m_zeros = 0;
                  end
               end
            end
         end else if (m_estado == E_PRONTA) begin
            if (aceita) begin
               m_estado = E_SOLTAR; m_zeros = 0;
            end
         end else begin
            if (s == 0) begin
               m_zeros++;
               if (m_zeros == D) m_estado = E_SOLTO;
            end else m_zeros = 0;
         end
         m_inv = inv;
         m_s2  = m_s1;
         m_s1  = botoes;
      end
   endtask

   task automatic compara();
      verifica("tem_jogada", int'(tem_jogada), int'(m_estado == E_PRONTA));
      verifica("db_estado", int'(db_estado), m_estado);
      verifica("posicao", int'(posicao), m_pos);
      verifica("jogada_invalida", int'(jogada_invalida), m_inv);
   endtask

   task automatic tick();
      @(posedge clock);
      modelo_passo();
      @(negedge clock);
      compara();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic espera_tem(input int max, output int n);
      n = 0;
      while (!tem_jogada && n < max) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n, cont_a, cont_b, r, len;

      reset = 1'b1; botoes = '0;
      ticks(2);
      verifica("rst_db", int'(db_estado), 0);
      verifica("rst_tem", int'(tem_jogada), 0);
      verifica("rst_pos", int'(posicao), 0);
      verifica("rst_inv", int'(jogada_invalida), 0);

      // single press: reset edge is edge 0, request visible after edge 7
      botoes = 9'b000010000;
      tick();
      reset = 1'b0;
      ticks(6);
      verifica("press_pre_tem", int'(tem_jogada), 0);
      tick();
      verifica("press_tem", int'(tem_jogada), 1);
      verifica("press_pos", int'(posicao), 4);
      verifica("press_db", int'(db_estado), 2);
      ticks(5);
      verifica("press_hold_tem", int'(tem_jogada), 1);

      // acknowledge with button still held
      aceita = 1'b1; tick(); aceita = 1'b0;
      verifica("ack_tem", int'(tem_jogada), 0);
      verifica("ack_db", int'(db_estado), 3);
      cont_a = 0;
      for (int i = 0; i < 10; i++) begin tick(); cont_a += int'(tem_jogada); end
      verifica("ack_no_recapture", cont_a, 0);
      botoes = '0; ticks(6);
      verifica("release_db", int'(db_estado), 0);
      botoes = 9'h100; espera_tem(20, n);
      verifica("b8_latency", n, 7);
      verifica("b8_pos", int'(posicao), 8);
      aceita = 1'b1; tick(); aceita = 1'b0;
      botoes = '0; ticks(8);

      // bounce on bit 0
      cont_a = 0;
      for (int i = 0; i < 12; i++) begin
         botoes = (((i / 2) % 2) == 0) ? 9'h001 : 9'h000;
         tick();
         cont_a += int'(tem_jogada);
      end
      verifica("bounce_tem", cont_a, 0);
      botoes = 9'h001; espera_tem(20, n);
      verifica("bounce_latency", n, 7);
      verifica("bounce_pos", int'(posicao), 0);
      aceita = 1'b1; tick(); aceita = 1'b0;
      botoes = '0; ticks(8);

      // multi-button press
      botoes = 9'b000000101; cont_a = 0; cont_b = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         cont_a += int'(jogada_invalida);
         cont_b += int'(tem_jogada);
      end
      verifica("multi_pulses", cont_a, INV_EN);
      verifica("multi_tem", cont_b, 0);
      verifica("multi_db", int'(db_estado), 3);
      botoes = '0; ticks(8);

      // limpa beats aceita, then limpa on the completion cycle
      botoes = 9'h040; espera_tem(20, n);
      verifica("b6_pos", int'(posicao), 6);
      limpa = 1'b1; aceita = 1'b1; tick(); limpa = 1'b0; aceita = 1'b0;
      verifica("limpa_ack_db", int'(db_estado), 3);
      verifica("limpa_ack_tem", int'(tem_jogada), 0);
      botoes = '0; ticks(8);
      botoes = 9'h002; ticks(6);
      verifica("limpa_pre_db", int'(db_estado), 1);
      limpa = 1'b1; tick(); limpa = 1'b0;
      verifica("limpa_fim_db", int'(db_estado), 3);
      cont_a = 0;
      for (int i = 0; i < 8; i++) begin tick(); cont_a += int'(tem_jogada); end
      verifica("limpa_fim_no_capture", cont_a, 0);
      verifica("limpa_fim_pos", int'(posicao), 6);
      botoes = '0; ticks(8);

      // reset in CONTANDO and in PRONTA
      botoes = 9'h008; ticks(4);
      verifica("rst_mid_pre_db", int'(db_estado), 1);
      reset = 1'b1; tick(); reset = 1'b0;
      verifica("rst_cont_db", int'(db_estado), 0);
      verifica("rst_cont_tem", int'(tem_jogada), 0);
      verifica("rst_cont_pos", int'(posicao), 0);
      espera_tem(20, n);
      verifica("b3_pos", int'(posicao), 3);
      reset = 1'b1; tick(); reset = 1'b0;
      verifica("rst_pronta_db", int'(db_estado), 0);
      verifica("rst_pronta_tem", int'(tem_jogada), 0);
      verifica("rst_pronta_pos", int'(posicao), 0);
      botoes = '0; ticks(8);

      // random traffic against the model
      for (int seg = 0; seg < 400; seg++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      botoes = 9'(1) << $urandom_range(0, 8);
         else if (r < 65) botoes = '0;
         else             botoes = 9'($urandom);
         len = $urandom_range(1, 12);
         for (int c = 0; c < len; c++) begin
            aceita = ($urandom_range(0, 3) == 0);
            limpa  = ($urandom_range(0, 39) == 0);
            reset  = ($urandom_range(0, 199) == 0);
            tick();
         end
      end
      reset = 1'b0; limpa = 1'b0; aceita = 1'b0; botoes = '0;
      ticks(10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_erros);
      $finish;
   end

endmodule
